// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-port round-robin front end for one single-port synchronous RAM.
// After reset it can optionally zero-fill the RAM.
// It then accepts at most one access per cycle and registers the RAM controls.
// Read data is steered back to the port that issued the read.
//
// Parameters:
//   A      address width (RAM depth 2^A)
//   D      data width
//   CLEAR  1 = zero-fill the RAM after reset before serving requests
//
// Ports:
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   req/we/addr/wdata 0,1     requester side; fields are held until granted
//   gnt0/gnt1                 combinational accept (handshake on req & gnt)
//   rvalid0/1, rdata0/1       one-cycle read return pulse with data
//   busy                      high while the clear sequence runs
//   ram_addr/ram_din/ram_we   registered RAM controls
//   ram_dout                  RAM read data (one cycle after address sample)
module ram_arbiter #(
    parameter int A     = 10,
    parameter int D     = 8,
    parameter bit CLEAR = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0,
    input  logic         we0,
    input  logic [A-1:0] addr0,
    input  logic [D-1:0] wdata0,
    input  logic         req1,
    input  logic         we1,
    input  logic [A-1:0] addr1,
    input  logic [D-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [D-1:0] rdata0,
    output logic [D-1:0] rdata1,
    output logic         busy,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t       RESET_STATE = CLEAR ? ST_CLEAR : ST_RUN;
    localparam logic [A-1:0] CNT_LAST    = '1;

    state_t       state_reg, state_next;
    logic [A-1:0] cnt_reg;
    logic         last_reg;        // port granted most recently
    logic [A-1:0] ram_addr_reg;
    logic [D-1:0] ram_din_reg;
    logic         ram_we_reg;
    // Read tag travels two stages: issued-to-RAM, then RAM-output-valid.
    logic         tag_valid_reg, tag_port_reg;
    logic         ret_valid_reg, ret_port_reg;

    logic [1:0]   req_vec, we_vec, gnt_vec, rvalid_vec;
    logic [A-1:0] addr_vec  [2];
    logic [D-1:0] wdata_vec [2];
    logic [D-1:0] rdata_vec [2];
    logic         accept;
    logic         sel;

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_CLEAR && cnt_reg == CNT_LAST) begin
            state_next = ST_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    // Grant goes to the lone requester, or on a tie to the port that did not
    // win last. Gated by reset_n so no grant is visible while reset is held.
    always_comb begin
        busy    = (state_reg == ST_CLEAR);
        gnt_vec = 2'b00;
        if (state_reg == ST_RUN && reset_n) begin
            if (req_vec[0] && (!req_vec[1] || last_reg)) begin
                gnt_vec[0] = 1'b1;
            end else if (req_vec[1]) begin
                gnt_vec[1] = 1'b1;
            end
        end
    end

    assign gnt0   = gnt_vec[0];
    assign gnt1   = gnt_vec[1];
    assign accept = |(req_vec & gnt_vec);
    assign sel    = gnt_vec[1];

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg       <= '0;
            last_reg      <= 1'b1;
            ram_addr_reg  <= '0;
            ram_din_reg   <= '0;
            ram_we_reg    <= 1'b0;
            tag_valid_reg <= 1'b0;
            tag_port_reg  <= 1'b0;
            ret_valid_reg <= 1'b0;
            ret_port_reg  <= 1'b0;
        end else begin
            ret_valid_reg <= tag_valid_reg;
            ret_port_reg  <= tag_port_reg;
            if (state_reg == ST_CLEAR) begin
                ram_addr_reg  <= cnt_reg;
                ram_din_reg   <= '0;
                ram_we_reg    <= 1'b1;
                cnt_reg       <= cnt_reg + 1'b1;
                tag_valid_reg <= 1'b0;
            end else if (accept) begin
                ram_addr_reg  <= addr_vec[sel];
                ram_din_reg   <= wdata_vec[sel];
                ram_we_reg    <= we_vec[sel];
                tag_valid_reg <= !we_vec[sel];
                tag_port_reg  <= sel;
                last_reg      <= sel;
            end else begin
                // Address and data hold; only the strobe and tag drop.
                ram_we_reg    <= 1'b0;
                tag_valid_reg <= 1'b0;
            end
        end
    end

    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;
    assign ram_we   = ram_we_reg;

    // ---------------- Read return steering ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign rvalid_vec[gi] = ret_valid_reg && (ret_port_reg == 1'(gi));
        assign rdata_vec[gi]  = ram_dout;
    end

    assign rvalid0 = rvalid_vec[0];
    assign rvalid1 = rvalid_vec[1];
    assign rdata0  = rdata_vec[0];
    assign rdata1  = rdata_vec[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter (A=4, D=8, CLEAR=1) with an attached RAM model.
// The reference model tracks memory contents as seen in grant order.
// It derives grants from the round-robin rule and expects each read's data
// two cycles after acceptance.
module tb_ram_arbiter;

    localparam int A = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0, we0, req1, we1;
    logic [A-1:0] addr0, addr1;
    logic [D-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [D-1:0] rdata0, rdata1, ram_din, ram_dout;
    logic [A-1:0] ram_addr;

    ram_arbiter #(.A(A), .D(D), .CLEAR(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered read.
    logic [D-1:0] ram_mem [2**A];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // ---------------- Checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct packed {
        logic         idle;
        logic         we;
        logic [A-1:0] addr;
        logic [D-1:0] wdata;
    } op_t;

    typedef struct {
        int           port;
        logic [D-1:0] data;
        int           due;
    } ret_t;

    op_t          q0[$], q1[$];
    ret_t         exp_q[$];
    op_t          pend_op[2];
    bit           pend_v[2];
    logic [D-1:0] mmem[2**A];
    int           m_last;
    int           cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 2**A; i++) mmem[i] = '0;
        m_last = 1;
        exp_q.delete();
        q0.delete();
        q1.delete();
        pend_v[0] = 0;
        pend_v[1] = 0;
    endtask

    function automatic op_t mk(input bit we, input int addr, input int data);
        op_t o;
        o.idle  = 1'b0;
        o.we    = we;
        o.addr  = A'(addr);
        o.wdata = D'(data);
        return o;
    endfunction

    task automatic drive();
        req0   = pend_v[0];
        we0    = pend_op[0].we;
        addr0  = pend_op[0].addr;
        wdata0 = pend_op[0].wdata;
        req1   = pend_v[1];
        we1    = pend_op[1].we;
        addr1  = pend_op[1].addr;
        wdata1 = pend_op[1].wdata;
    endtask

    task automatic check_returns();
        bit ev0, ev1;
        ev0 = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].port == 0;
        ev1 = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].port == 1;
        chk("rvalid0", 32'(rvalid0), 32'(ev0));
        chk("rvalid1", 32'(rvalid1), 32'(ev1));
        if (ev0) chk("rdata0", 32'(rdata0), 32'(exp_q[0].data));
        if (ev1) chk("rdata1", 32'(rdata1), 32'(exp_q[0].data));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
    endtask

    // One iteration per clock: check returns, issue new ops, check grants.
    task automatic run_cycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int  exp_g;
            op_t h;
            @(posedge clk);
            cyc++;
            #1;
            check_returns();
            for (int p = 0; p < 2; p++) begin
                if (!pend_v[p]) begin
                    op_t o;
                    bit  got;
                    got = 1'b0;
                    o   = '0;
                    if (p == 0 && q0.size() > 0) begin
                        o = q0.pop_front(); got = 1'b1;
                    end else if (p == 1 && q1.size() > 0) begin
                        o = q1.pop_front(); got = 1'b1;
                    end else if (rnd && $urandom_range(2) != 0) begin
                        o = mk($urandom_range(1), $urandom_range(2**A - 1), $urandom_range(255));
                        got = 1'b1;
                    end
                    if (got && !o.idle) begin
                        pend_v[p]  = 1;
                        pend_op[p] = o;
                    end
                end
            end
            drive();
            #1;
            if (pend_v[0] && pend_v[1]) exp_g = 1 - m_last;
            else if (pend_v[0])         exp_g = 0;
            else if (pend_v[1])         exp_g = 1;
            else                        exp_g = -1;
            chk("gnt0", 32'(gnt0), 32'(exp_g == 0));
            chk("gnt1", 32'(gnt1), 32'(exp_g == 1));
            if (exp_g >= 0) begin
                h = pend_op[exp_g];
                if (h.we) mmem[h.addr] = h.wdata;
                else exp_q.push_back('{port: exp_g, data: mmem[h.addr], due: cyc + 2});
                m_last        = exp_g;
                pend_v[exp_g] = 0;
            end
        end
    endtask

    // Called right after reset release, before the first edge.
    task automatic check_clear();
        req0 = 1'b1; we0 = 1'b0; addr0 = '0;
        chk("clr_we_pre", 32'(ram_we), 32'd0);
        for (int k = 0; k < 2**A; k++) begin
            chk("clr_busy", 32'(busy), 32'd1);
            chk("clr_gnt0", 32'(gnt0), 32'd0);
            @(posedge clk);
            #1;
            chk("clr_we", 32'(ram_we), 32'd1);
            chk("clr_addr", 32'(ram_addr), 32'(k));
            chk("clr_din", 32'(ram_din), 32'd0);
        end
        req0 = 1'b0;
        chk("clr_busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pend_op[0] = '0;
        pend_op[1] = '0;
        #23;
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_clear();
        model_reset();

        // Contention straight after reset: port 0 must win the first tie.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(0, 1 + i, 0));
            q1.push_back(mk(0, 4 + i, 0));
        end
        run_cycles(10, 0);

        // Cleared contents read back on port 0.
        for (int i = 0; i < 2**A; i++) q0.push_back(mk(0, i, 0));
        run_cycles(20, 0);

        // Single port write then read.
        q0.push_back(mk(1, 3, 8'h5A));
        q0.push_back(mk(0, 3, 0));
        run_cycles(6, 0);

        // Read-after-write across ports, one cycle apart.
        q1.push_back(mk(1, 7, 8'h33));
        q0.push_back('{idle: 1'b1, we: 1'b0, addr: '0, wdata: '0});
        q0.push_back(mk(0, 7, 0));
        run_cycles(6, 0);

        // Back-to-back reads on port 1.
        q1.push_back(mk(0, 3, 0));
        q1.push_back(mk(0, 7, 0));
        q1.push_back(mk(0, 8, 0));
        q1.push_back(mk(0, 9, 0));
        run_cycles(8, 0);

        // Random traffic on both ports, then drain.
        run_cycles(400, 1);
        run_cycles(6, 0);
        chk("retq_empty1", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the clear sequence.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_addr", 32'(ram_addr), 32'd8);
        req0 = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(ram_we), 32'd0);
        chk("mid_rst_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_gnt0", 32'(gnt0), 32'd0);
        chk("mid_rst_rvalid0", 32'(rvalid0), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_clear();
        model_reset();

        // Tie priority restored by reset, then random traffic on fresh RAM.
        q0.push_back(mk(0, 12, 0));
        q1.push_back(mk(0, 13, 0));
        run_cycles(6, 0);
        run_cycles(150, 1);
        run_cycles(6, 0);
        chk("retq_empty2", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
